// File: rtl/mult_seq_pkg.sv
// Shared widths, cycle counts and state encoding for the sequential multiplier.
package mult_seq_pkg;

  localparam int unsigned A_W      = 4;
  localparam int unsigned B_W      = 3;
  localparam int unsigned P_W      = 8;
  localparam int unsigned MULT_CYC = 3;
  localparam int unsigned BCD_CYC  = 8;
  localparam int unsigned DIG_W    = 4;
  localparam int unsigned SR_W     = P_W + 3 * DIG_W;
  localparam int unsigned CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_BCD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : mult_seq_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_add3
  import mult_seq_pkg::*;
(
  input  logic [DIG_W-1:0] digit_i,
  output logic [DIG_W-1:0] digit_o
);

  // Correct the digit before the next left shift
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIG_W'(5)) begin
      digit_o = digit_i + DIG_W'(3);
    end
  end

endmodule : bcd_add3

// File: rtl/mult_seq_controller.sv
// Shift-and-add 4x3 multiplier followed by an 8-cycle binary-to-BCD conversion.
module mult_seq_controller
  import mult_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [P_W-1:0]   product,
  output logic [DIG_W-1:0] bcd_hund,
  output logic [DIG_W-1:0] bcd_tens,
  output logic [DIG_W-1:0] bcd_ones
);

  state_e            state_q, state_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [P_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [P_W-1:0]    product_q, product_d;
  logic [DIG_W-1:0]  hund_q, hund_d;
  logic [DIG_W-1:0]  tens_q, tens_d;
  logic [DIG_W-1:0]  ones_q, ones_d;

  logic [1:0]        mult_idx;
  logic [P_W-1:0]    acc_next;
  logic [DIG_W-1:0]  hund_adj, tens_adj, ones_adj;
  logic [SR_W-1:0]   sr_corr;
  logic [SR_W-1:0]   sr_step;

  // Digit corrections for the hundreds, tens and ones fields of the shift register
  bcd_add3 u_add3_hund (.digit_i(sr_q[SR_W-1 -: DIG_W]),         .digit_o(hund_adj));
  bcd_add3 u_add3_tens (.digit_i(sr_q[SR_W-1-DIG_W -: DIG_W]),   .digit_o(tens_adj));
  bcd_add3 u_add3_ones (.digit_i(sr_q[SR_W-1-2*DIG_W -: DIG_W]), .digit_o(ones_adj));

  // One multiply step and one double-dabble step, computed from current state
  always_comb begin
    mult_idx = cnt_q[1:0];
    acc_next = acc_q;
    if (b_q[mult_idx]) begin
      acc_next = acc_q + (P_W'(a_q) << mult_idx);
    end
    sr_corr = {hund_adj, tens_adj, ones_adj, sr_q[P_W-1:0]};
    sr_step = {sr_corr[SR_W-2:0], 1'b0};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    product_d = product_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        acc_d = acc_next;
        if (cnt_q == CNT_W'(MULT_CYC - 1)) begin
          sr_d    = {(SR_W - P_W)'(0), acc_next};
          cnt_d   = '0;
          state_d = ST_BCD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BCD: begin
        sr_d = sr_step;
        if (cnt_q == CNT_W'(BCD_CYC - 1)) begin
          product_d = acc_q;
          hund_d    = sr_step[SR_W-1 -: DIG_W];
          tens_d    = sr_step[SR_W-1-DIG_W -: DIG_W];
          ones_d    = sr_step[SR_W-1-2*DIG_W -: DIG_W];
          cnt_d     = '0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_MULT) || (state_d == ST_BCD);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sr_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign bcd_hund = hund_q;
  assign bcd_tens = tens_q;
  assign bcd_ones = ones_q;

endmodule : mult_seq_controller

// File: doc/mult_seq_controller.md
MULT_SEQ_CONTROLLER -- requirements
Module: mult_seq_controller

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request one multiply, sampled only in IDLE.
REQ-004 SHALL have ports: a  input  4  unsigned multiplicand, captured on start acceptance.
REQ-005 SHALL have ports: b  input  3  unsigned multiplier, captured on start acceptance.
REQ-006 SHALL have ports: busy  output  1  high while in MULT or BCD.
REQ-007 SHALL have ports: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports: product  output  8  registered binary result a*b.
REQ-009 SHALL have ports: bcd_hund, bcd_tens, bcd_ones  output  4 each  registered BCD digits of product.
REQ-010 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-011 SHALL implement FSM states IDLE, MULT, BCD, DONE.
REQ-012 IDLE: start=1 at a rising edge SHALL latch a and b, clear the accumulator and step counter, and go to MULT; start=0 stays in IDLE.
REQ-013 MULT SHALL run exactly 3 cycles; at step i (0..2), if latched b[i]=1, acc SHALL become acc + (a_latched << i), 8-bit, no overflow (max 15*7=105).
REQ-014 After step 2, the FSM SHALL load a 20-bit shift register {12'b0, acc} and go to BCD.
REQ-015 BCD SHALL run exactly 8 cycles of double-dabble; each cycle SHALL add 3 to every 4-bit digit field >=5, then shift the whole register left by 1.
REQ-016 After the 8th BCD cycle, the FSM SHALL load product=acc and the three digit fields into the output registers, and go to DONE.
REQ-017 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after the 11th rising edge following the accepting edge; busy SHALL be high for the 11 cycles between.
REQ-019 start while in MULT, BCD or DONE SHALL be ignored (not queued); a, b changes after acceptance SHALL not affect the result.
REQ-020 start held high continuously SHALL yield back-to-back operations, one every 13 cycles (IDLE re-accepts on the edge after DONE).
REQ-021 product and BCD outputs SHALL hold their values until the next DONE entry; they SHALL not show intermediate values.
REQ-022 b=0 or a=0 SHALL complete with full latency and product=0, all digits 0.
REQ-023 done and busy SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, product=0, all digits=0, and clear the accumulator, counter and shift register.
REQ-025 Reset mid-operation SHALL abort it with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-026 Shared package mult_seq_pkg SHALL hold the state enum, widths A_W=4, B_W=3, P_W=8, and cycle counts MULT_CYC=3, BCD_CYC=8.
REQ-027 The add-3 correction SHALL be a sub-module bcd_add3 (4-bit in, 4-bit out, combinational), instantiated three times.
REQ-028 All outputs SHALL be driven directly from flops.

Verification
REQ-029 a=3, b=2, start for 1 cycle -> done after 11 edges, product=6, digits 0/0/6, busy high exactly 11 cycles.
REQ-030 a=15, b=7 -> product=105 (8'h69), digits 1/0/5.
REQ-031 a=9, b=0 and a=0, b=5 -> product=0, digits 0/0/0, full latency.
REQ-032 a=5, b=3 accepted, then start pulsed with a=1, b=1 during MULT/BCD -> single done, product=15, digits 0/1/5.
REQ-033 rst asserted on the 5th busy cycle -> outputs zero immediately, no done; then a=12, b=6 -> product=72, digits 0/7/2.
REQ-034 start held high, all 128 (a, b) pairs swept -> each done matches the a*b and BCD reference model, spaced 13 cycles apart.
